// File: rtl/lopd_pkg.sv
// Shared types and sizing helpers for the pipelined leading-one position detector.
package lopd_pkg;

  localparam int LEAF_W = 4;

  typedef struct packed {
    logic [1:0] pos;
    logic       zero;
  } lopd_leaf_t;

  function automatic int pos_w(input int width);
    return $clog2(width);
  endfunction

  function automatic int group_cnt(input int width);
    return width / LEAF_W;
  endfunction

endpackage

// File: rtl/lopd_grp_select.sv
// Priority encoder: index of the most significant group whose leaf is non-zero.
module lopd_grp_select #(
  parameter int G     = 6,
  parameter int SEL_W = 3
) (
  input  logic [G-1:0]     gzero,
  output logic [SEL_W-1:0] grp
);

  // Ascending scan, so the last non-zero group written is the highest one.
  always_comb begin
    grp = '0;
    for (int g = 0; g < G; g++) begin
      if (!gzero[g]) grp = SEL_W'(g);
    end
  end

endmodule

// File: rtl/lopd_leaf4.sv
// 4-bit leading-one leaf cell: index of the highest set bit and an all-zero flag.
module lopd_leaf4
  import lopd_pkg::*;
(
  input  logic [LEAF_W-1:0] data,
  output lopd_leaf_t        leaf
);

  // NOTE: every output gets a default before the priority chain, so no path leaves it unassigned (no latch).
  always_comb begin
    leaf.zero = ~|data;
    leaf.pos  = 2'd0;
    if (data[3])      leaf.pos = 2'd3;
    else if (data[2]) leaf.pos = 2'd2;
    else if (data[1]) leaf.pos = 2'd1;
  end

endmodule

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading-one detector with normalising left shift and valid/ready flow control.
module lopd_norm_pipe
  import lopd_pkg::*;
#(
  parameter int  WIDTH = 24,
  parameter int  TAG_W = 9,
  localparam int POS_W = pos_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [POS_W-1:0] o_pos_one,
  output logic             o_zero_flag,
  output logic [WIDTH-1:0] o_norm_data,
  output logic [TAG_W-1:0] o_tag
);

  localparam int G      = group_cnt(WIDTH);
  localparam int GSEL_W = (G > 1) ? $clog2(G) : 1;

  logic                 adv1, adv2;
  lopd_leaf_t [G-1:0]   leaf_c;
  logic                 s1_valid;
  lopd_leaf_t [G-1:0]   s1_leaf;
  logic [WIDTH-1:0]     s1_data;
  logic [TAG_W-1:0]     s1_tag;
  logic [G-1:0]         s1_gzero;
  logic [GSEL_W-1:0]    grp_c;
  logic                 zero_c;
  logic [POS_W-1:0]     pos_c;
  logic [POS_W-1:0]     shamt_c;
  logic [WIDTH-1:0]     norm_c;

  assign adv2    = ~o_valid | i_ready;
  assign adv1    = ~s1_valid | adv2;
  assign o_ready = adv1;

  for (genvar g = 0; g < G; g++) begin : g_leaf
    lopd_leaf4 u_leaf (
      .data (i_data[LEAF_W*g +: LEAF_W]),
      .leaf (leaf_c[g])
    );
    assign s1_gzero[g] = s1_leaf[g].zero;
  end

  lopd_grp_select #(
    .G     (G),
    .SEL_W (GSEL_W)
  ) u_sel (
    .gzero (s1_gzero),
    .grp   (grp_c)
  );

  assign zero_c = &s1_gzero;

  always_comb begin
    pos_c = '0;
    if (!zero_c) pos_c = POS_W'({grp_c, s1_leaf[grp_c].pos});
  end

  assign shamt_c = POS_W'(WIDTH - 1) - pos_c;
  assign norm_c  = s1_data << shamt_c;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) s1_valid <= 1'b0;
    else if (adv1) s1_valid <= i_valid;
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it needs no reset and stays a plain enable flop.
  always_ff @(posedge i_clk) begin
    if (adv1 && i_valid) begin
      s1_leaf <= leaf_c;
      s1_data <= i_data;
      s1_tag  <= i_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_pos_one   <= '0;
      o_zero_flag <= 1'b0;
      o_norm_data <= '0;
      o_tag       <= '0;
    end else if (adv2) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_pos_one   <= pos_c;
        o_zero_flag <= zero_c;
        o_norm_data <= norm_c;
        o_tag       <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Scoreboard bench for lopd_norm_pipe: directed vectors, back-pressure, random streaming, mid-stream reset.
module tb_lopd_norm_pipe;

  typedef struct {
    logic [4:0]  pos;
    logic        zero;
    logic [23:0] norm;
    logic [8:0]  tag;
    bit          lat;
    int          acc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_data;
  logic [8:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_pos_one;
  logic        o_zero_flag;
  logic [23:0] o_norm_data;
  logic [8:0]  o_tag;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ready_mode = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  lopd_norm_pipe #(.WIDTH(24), .TAG_W(9)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_tag       (i_tag),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_pos_one   (o_pos_one),
    .o_zero_flag (o_zero_flag),
    .o_norm_data (o_norm_data),
    .o_tag       (o_tag)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t mk(input logic [4:0] p, input logic z, input logic [23:0] n,
                              input logic [8:0] t, input bit lat);
    exp_t e;
    e.pos = p; e.zero = z; e.norm = n; e.tag = t; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [23:0] d, input logic [8:0] t);
    exp_t e;
    e = mk(5'd0, 1'b1, 24'h0, t, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (d[i]) begin
        e.pos  = 5'(i);
        e.zero = 1'b0;
      end
    end
    e.norm = d << (5'd23 - e.pos);
    return e;
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(3) != 0);
        default: i_ready = 1'b0;
      endcase
    end
  end

  task automatic set_ready(input int m);
    @(negedge i_clk);
    ready_mode = m;
    @(posedge i_clk);
    #2;
  endtask

  task automatic send(input logic [23:0] d, input exp_t e);
    int  waited;
    bit  done;
    i_data  = d;
    i_tag   = e.tag;
    i_valid = 1'b1;
    waited  = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge i_clk);
      if (o_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          fail("accept_timeout");
          i_valid = 1'b0;
          return;
        end
      end
    end
    e.acc = cyc;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      @(negedge i_clk);
      waited++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold stability while stalled.
  initial begin
    exp_t        e;
    bit          hold_pend;
    logic [39:0] held;
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge i_clk);
      if (!mon_en || i_rst_n !== 1'b1) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend)
          check("hold_stable", 64'({o_valid, o_pos_one, o_zero_flag, o_norm_data, o_tag}), 64'(held));
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            fail("unexpected_beat");
          end else begin
            e = sb.pop_front();
            check("pos",  64'(o_pos_one),   64'(e.pos));
            check("zero", 64'(o_zero_flag), 64'(e.zero));
            check("norm", 64'(o_norm_data), 64'(e.norm));
            check("tag",  64'(o_tag),       64'(e.tag));
            if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
          end
        end
        hold_pend = o_valid && !i_ready;
        held      = {o_valid, o_pos_one, o_zero_flag, o_norm_data, o_tag};
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] d;
    logic [8:0]  t;
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_tag   = '0;
    #2 i_rst_n = 1'b0;

    repeat (2) @(negedge i_clk);
    check("rst_valid", 64'(o_valid),     64'd0);
    check("rst_pos",   64'(o_pos_one),   64'd0);
    check("rst_zero",  64'(o_zero_flag), 64'd0);
    check("rst_norm",  64'(o_norm_data), 64'd0);
    check("rst_tag",   64'(o_tag),       64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_rst", 64'(o_ready), 64'd1);
    mon_en = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed single beats with latency checks.
    send(24'h000001, mk(5'd0,  1'b0, 24'h800000, 9'h055, 1'b1));
    drain();
    send(24'h800000, mk(5'd23, 1'b0, 24'h800000, 9'h100, 1'b1));
    send(24'h00F0A5, mk(5'd15, 1'b0, 24'hF0A500, 9'h0A5, 1'b1));
    send(24'h000000, mk(5'd0,  1'b1, 24'h000000, 9'h1FF, 1'b1));
    send(24'h000007, mk(5'd2,  1'b0, 24'hE00000, 9'h007, 1'b1));
    send(24'h080000, mk(5'd19, 1'b0, 24'h800000, 9'h013, 1'b1));
    send(24'h000A00, mk(5'd11, 1'b0, 24'hA00000, 9'h0B0, 1'b1));
    drain();

    // Back-pressure: two beats fill the pipe, the rest wait until the stall lifts.
    set_ready(2);
    send(24'h000010, mk(5'd4,  1'b0, 24'h800000, 9'h001, 1'b0));
    send(24'h000100, mk(5'd8,  1'b0, 24'h800000, 9'h002, 1'b0));
    @(negedge i_clk);
    check("bp_ready_low", 64'(o_ready), 64'd0);
    check("bp_valid_high", 64'(o_valid), 64'd1);
    fork
      begin
        repeat (4) @(negedge i_clk);
        ready_mode = 0;
      end
    join_none
    send(24'h001000, mk(5'd12, 1'b0, 24'h800000, 9'h003, 1'b0));
    check("shift_ready", 64'(o_ready), 64'd1);
    send(24'h010000, mk(5'd16, 1'b0, 24'h800000, 9'h004, 1'b0));
    drain();

    // Random streaming against the reference model.
    set_ready(1);
    for (int k = 0; k < 10000; k++) begin
      d = 24'($urandom() >> $urandom_range(31));
      if ($urandom_range(15) == 0) d = '0;
      t = 9'($urandom());
      if ($urandom_range(3) == 0) begin
        @(posedge i_clk);
        #1;
      end
      send(d, model(d, t));
    end
    set_ready(0);
    drain();

    // Asynchronous reset with two beats in flight.
    set_ready(2);
    send(24'h000001, mk(5'd0,  1'b0, 24'h800000, 9'h033, 1'b0));
    send(24'h400000, mk(5'd22, 1'b0, 24'h800000, 9'h044, 1'b0));
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid),     64'd0);
    check("mid_rst_pos",   64'(o_pos_one),   64'd0);
    check("mid_rst_norm",  64'(o_norm_data), 64'd0);
    check("mid_rst_tag",   64'(o_tag),       64'd0);
    sb.delete();
    set_ready(0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_ready", 64'(o_ready), 64'd1);
    repeat (2) begin
      @(negedge i_clk);
      check("no_partial_out", 64'(o_valid), 64'd0);
    end
    @(posedge i_clk);
    #1;
    send(24'h000300, mk(5'd9, 1'b0, 24'hC00000, 9'h0AA, 1'b1));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
